// File: rtl/decode_instr_queue_if.sv
// ---------------------------------------------------------------------------
// decode_instr_queue_if
//   Bundle of every signal between fetch, the decode instruction queue and the
//   decoder. The queue itself connects through the 'slave' modport; whatever
//   drives fetch/decode traffic (a front end, or a bench) uses 'master'.
//
// Handshake rules:
//   Enqueue: fetch may present any set of enq_valid lanes. The whole packet is
//   taken on a rising edge when enq_ready=1; enq_ready depends only on the
//   registered occupancy. A packet offered while enq_ready=0 is dropped.
//   Dequeue: deq_valid is contiguous from lane 0. When deq_ready=1 on a rising
//   edge, every lane with deq_valid=1 is consumed. deq_ready with no valid
//   lanes does nothing. flush beats both enqueue and dequeue.
//
// Signals (widths in terms of the parameters):
//   flush                    1          discard all queued entries
//   enq_valid                ENQ_W      per-lane valid
//   enq_instr                ENQ_W*32   lane i at [32i+:32]
//   enq_is_sfb               ENQ_W      short-forward-branch tag
//   enq_xcpt_pf_if           ENQ_W      fetch page fault
//   enq_xcpt_ae_if           ENQ_W      fetch access fault
//   enq_bp_debug_if          ENQ_W      debug breakpoint hit
//   enq_bp_xcpt_if           ENQ_W      breakpoint exception hit
//   enq_ready                1          a full ENQ_W packet fits
//   io_interrupt             1          interrupt pending
//   io_interrupt_cause       XLEN       cause for the pending interrupt
//   deq_valid                DEQ_W      per-lane valid
//   deq_ready                1          decoder takes all valid lanes
//   deq_instr                DEQ_W*32   lane instruction
//   deq_is_sfb               DEQ_W      lane sfb tag
//   deq_exception            DEQ_W      lane raises an exception
//   deq_exc_cause            DEQ_W*XLEN lane cause, lane i at [XLEN*i+:XLEN]
//   count                    clog2(DEPTH+1) occupied entries
//   empty / full             1          count==0 / count==DEPTH
// ---------------------------------------------------------------------------
interface decode_instr_queue_if #(
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                    flush;
    logic [ENQ_W-1:0]        enq_valid;
    logic [ENQ_W*32-1:0]     enq_instr;
    logic [ENQ_W-1:0]        enq_is_sfb;
    logic [ENQ_W-1:0]        enq_xcpt_pf_if;
    logic [ENQ_W-1:0]        enq_xcpt_ae_if;
    logic [ENQ_W-1:0]        enq_bp_debug_if;
    logic [ENQ_W-1:0]        enq_bp_xcpt_if;
    logic                    enq_ready;
    logic                    io_interrupt;
    logic [XLEN-1:0]         io_interrupt_cause;
    logic [DEQ_W-1:0]        deq_valid;
    logic                    deq_ready;
    logic [DEQ_W*32-1:0]     deq_instr;
    logic [DEQ_W-1:0]        deq_is_sfb;
    logic [DEQ_W-1:0]        deq_exception;
    logic [DEQ_W*XLEN-1:0]   deq_exc_cause;
    logic [CW-1:0]           count;
    logic                    empty;
    logic                    full;

    modport master (
        output flush, enq_valid, enq_instr, enq_is_sfb, enq_xcpt_pf_if,
               enq_xcpt_ae_if, enq_bp_debug_if, enq_bp_xcpt_if,
               io_interrupt, io_interrupt_cause, deq_ready,
        input  enq_ready, deq_valid, deq_instr, deq_is_sfb, deq_exception,
               deq_exc_cause, count, empty, full
    );

    modport slave (
        input  flush, enq_valid, enq_instr, enq_is_sfb, enq_xcpt_pf_if,
               enq_xcpt_ae_if, enq_bp_debug_if, enq_bp_xcpt_if,
               io_interrupt, io_interrupt_cause, deq_ready,
        output enq_ready, deq_valid, deq_instr, deq_is_sfb, deq_exception,
               deq_exc_cause, count, empty, full
    );
endinterface

// File: rtl/decode_instr_queue.sv
// ---------------------------------------------------------------------------
// decode_instr_queue
//   Multi-lane circular instruction queue sitting between fetch and the
//   decoder. Takes up to ENQ_W instructions per cycle (with their front-end
//   fault/breakpoint bits), and presents up to DEQ_W in-order lanes to decode
//   with each lane's exception already resolved to a single flag + cause.
//   A pending interrupt is injected on lane 0 and narrows the packet to that
//   one lane.
//
// Ports:
//   clk    in  rising-edge clock
//   rstn   in  asynchronous active-low reset; drops every entry
//   q      slave modport of decode_instr_queue_if (enqueue, dequeue,
//          interrupt, flush and occupancy signals; see the interface)
//
// DEPTH must be a power of two (head/tail wrap by plain overflow) and at least
// 2; ENQ_W is 1..4 and DEQ_W is 1..DEPTH.
// ---------------------------------------------------------------------------
module decode_instr_queue #(
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    decode_instr_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Exception causes for front-end faults (RISC-V mcause encodings; 14 is
    // the value the core uses internally for a debug trigger).
    localparam logic [XLEN-1:0] CAUSE_DEBUG_TRIGGER  = XLEN'(14);
    localparam logic [XLEN-1:0] CAUSE_BREAKPOINT     = XLEN'(3);
    localparam logic [XLEN-1:0] CAUSE_FETCH_PAGE     = XLEN'(12);
    localparam logic [XLEN-1:0] CAUSE_FETCH_ACCESS   = XLEN'(1);

    // -----------------------------------------------------------------------
    // Storage. Entry contents are never reset: only head/tail/count decide
    // what is live, so stale data in free slots is harmless.
    // -----------------------------------------------------------------------
    logic [31:0]      mem_instr [DEPTH];
    logic [DEPTH-1:0] mem_sfb;
    logic [DEPTH-1:0] mem_pf;
    logic [DEPTH-1:0] mem_ae;
    logic [DEPTH-1:0] mem_bpd;
    logic [DEPTH-1:0] mem_bpx;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    // -----------------------------------------------------------------------
    // Enqueue side
    // -----------------------------------------------------------------------
    logic [PW-1:0]    enq_slot [ENQ_W];
    logic [CW-1:0]    n_enq;
    logic             do_enq;

    // Ready is judged from the registered count alone, so a packet is only
    // accepted when it fits even if the decoder takes nothing this cycle.
    assign q.enq_ready = ((DEPTH - int'(count)) >= ENQ_W);

    // Valid lanes are packed densely from tail: each lane's slot is tail plus
    // the number of valid lanes below it, so holes in enq_valid never leave
    // holes in the queue.
    always_comb begin : enq_compact
        n_enq = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            enq_slot[i] = tail + n_enq[PW-1:0];
            if (q.enq_valid[i]) begin
                n_enq = n_enq + CW'(1);
            end
        end
    end

    assign do_enq = q.enq_ready && (|q.enq_valid) && !q.flush;

    always_ff @(posedge clk) begin : storage_write
        for (int i = 0; i < ENQ_W; i++) begin
            if (do_enq && q.enq_valid[i]) begin
                mem_instr[enq_slot[i]] <= q.enq_instr[32*i +: 32];
                mem_sfb[enq_slot[i]]   <= q.enq_is_sfb[i];
                mem_pf[enq_slot[i]]    <= q.enq_xcpt_pf_if[i];
                mem_ae[enq_slot[i]]    <= q.enq_xcpt_ae_if[i];
                mem_bpd[enq_slot[i]]   <= q.enq_bp_debug_if[i];
                mem_bpx[enq_slot[i]]   <= q.enq_bp_xcpt_if[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Dequeue side: per-lane view of the head entries and their resolved
    // exception, before any packet masking.
    // -----------------------------------------------------------------------
    logic [PW-1:0]    deq_idx [DEQ_W];
    logic [DEQ_W-1:0] lane_live;
    logic [DEQ_W-1:0] lane_exc;
    logic [XLEN-1:0]  lane_cause [DEQ_W];

    always_comb begin : lane_resolve
        for (int j = 0; j < DEQ_W; j++) begin
            deq_idx[j]    = head + PW'(j);
            lane_live[j]  = (int'(count) > j);
            lane_exc[j]   = 1'b1;
            lane_cause[j] = '0;
            // An interrupt outranks anything the head instruction carries.
            if ((j == 0) && q.io_interrupt) begin
                lane_cause[j] = q.io_interrupt_cause;
            end else if (mem_bpd[deq_idx[j]]) begin
                lane_cause[j] = CAUSE_DEBUG_TRIGGER;
            end else if (mem_bpx[deq_idx[j]]) begin
                lane_cause[j] = CAUSE_BREAKPOINT;
            end else if (mem_pf[deq_idx[j]]) begin
                lane_cause[j] = CAUSE_FETCH_PAGE;
            end else if (mem_ae[deq_idx[j]]) begin
                lane_cause[j] = CAUSE_FETCH_ACCESS;
            end else begin
                lane_exc[j]   = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Packet formation. A lane is offered only if every lane before it was
    // offered and none of them excepts, so a packet carries at most one
    // exception and it is always the last lane. An interrupt limits the
    // packet to lane 0 so the trap is taken on a precise boundary.
    // -----------------------------------------------------------------------
    logic             blocked;
    logic [CW-1:0]    n_deq;
    logic             do_deq;

    always_comb begin : lane_select
        blocked         = 1'b0;
        n_deq           = '0;
        q.deq_valid     = '0;
        q.deq_instr     = '0;
        q.deq_is_sfb    = '0;
        q.deq_exception = '0;
        q.deq_exc_cause = '0;
        for (int j = 0; j < DEQ_W; j++) begin
            if (lane_live[j] && !blocked && !(q.io_interrupt && (j != 0))) begin
                q.deq_valid[j]          = 1'b1;
                q.deq_instr[32*j +: 32] = mem_instr[deq_idx[j]];
                q.deq_is_sfb[j]         = mem_sfb[deq_idx[j]];
                if (lane_exc[j]) begin
                    q.deq_exception[j]              = 1'b1;
                    q.deq_exc_cause[XLEN*j +: XLEN] = lane_cause[j];
                    blocked                         = 1'b1;
                end
                n_deq = n_deq + CW'(1);
            end
        end
    end

    assign do_deq = q.deq_ready && (|q.deq_valid) && !q.flush;

    // -----------------------------------------------------------------------
    // Pointers and occupancy. count cannot overflow: enqueue only happens
    // when a whole ENQ_W packet fits in the pre-dequeue free space.
    // -----------------------------------------------------------------------
    logic [CW-1:0] enq_amt;
    logic [CW-1:0] deq_amt;

    assign enq_amt = do_enq ? n_enq : '0;
    assign deq_amt = do_deq ? n_deq : '0;

    always_ff @(posedge clk or negedge rstn) begin : ptr_regs
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (q.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + enq_amt[PW-1:0];
            head  <= head + deq_amt[PW-1:0];
            count <= count + enq_amt - deq_amt;
        end
    end

    assign q.count = count;
    assign q.empty = (count == '0);
    assign q.full  = (int'(count) == DEPTH);

endmodule

// File: tb/tb_decode_instr_queue.sv
module tb_decode_instr_queue;

  localparam int ENQ_W = 2;
  localparam int DEQ_W = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = 37; // {bpx, bpd, ae, pf, sfb, instr[31:0]}
  localparam logic [XLEN-1:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  decode_instr_queue_if #(.ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  decode_instr_queue #(.ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk  (clk),
    .rstn (rstn),
    .q    (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fl, input logic [ENQ_W-1:0] ev,
                       input logic [ENQ_W*32-1:0] ei, input logic [ENQ_W-1:0] sfb,
                       input logic [ENQ_W-1:0] pf, input logic [ENQ_W-1:0] ae,
                       input logic [ENQ_W-1:0] bpd, input logic [ENQ_W-1:0] bpx,
                       input logic intr, input logic [XLEN-1:0] icause, input logic dr);
    bus.flush              = fl;
    bus.enq_valid          = ev;
    bus.enq_instr          = ei;
    bus.enq_is_sfb         = sfb;
    bus.enq_xcpt_pf_if     = pf;
    bus.enq_xcpt_ae_if     = ae;
    bus.enq_bp_debug_if    = bpd;
    bus.enq_bp_xcpt_if     = bpx;
    bus.io_interrupt       = intr;
    bus.io_interrupt_cause = icause;
    bus.deq_ready          = dr;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic enq2(input logic [31:0] a, input logic [31:0] b, input logic dr);
    drive(1'b0, 2'b11, {b, a}, '0, '0, '0, '0, '0, 1'b0, '0, dr);
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // The queue is exp_q; the decoder view is the first entries of it, cut
  // after the first trapping entry and to one entry under an interrupt.
  task automatic model_expect(output logic [DEQ_W-1:0] e_valid, output logic [DEQ_W*32-1:0] e_instr,
                              output logic [DEQ_W-1:0] e_sfb, output logic [DEQ_W-1:0] e_exc,
                              output logic [DEQ_W*XLEN-1:0] e_cause);
    logic [EW-1:0] ent;
    logic [XLEN-1:0] cause;
    logic exc;
    e_valid = '0; e_instr = '0; e_sfb = '0; e_exc = '0; e_cause = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      if (j >= exp_q.size()) break;
      if (bus.io_interrupt && j > 0) break;
      ent = exp_q[j];
      exc = 1'b1;
      if (j == 0 && bus.io_interrupt) cause = bus.io_interrupt_cause;
      else if (ent[35]) cause = 14;
      else if (ent[36]) cause = 3;
      else if (ent[33]) cause = 12;
      else if (ent[34]) cause = 1;
      else begin cause = 0; exc = 1'b0; end
      e_valid[j] = 1'b1;
      e_instr[32*j +: 32] = ent[31:0];
      e_sfb[j] = ent[32];
      e_exc[j] = exc;
      e_cause[XLEN*j +: XLEN] = cause;
      if (exc) break;
    end
  endtask

  // One clock of traffic with the current inputs: optionally compare the DUT
  // against the model, then advance the model across the rising edge.
  task automatic run_cycle(input bit check_model);
    logic [DEQ_W-1:0] e_valid, e_sfb, e_exc;
    logic [DEQ_W*32-1:0] e_instr;
    logic [DEQ_W*XLEN-1:0] e_cause;
    int n_deq;
    bit ready;
    #1;
    model_expect(e_valid, e_instr, e_sfb, e_exc, e_cause);
    ready = (DEPTH - exp_q.size()) >= ENQ_W;
    if (check_model) begin
      chk("m_deq_valid", bus.deq_valid, e_valid);
      chk("m_deq_instr", bus.deq_instr, e_instr);
      chk("m_deq_sfb", bus.deq_is_sfb, e_sfb);
      chk("m_deq_exc", bus.deq_exception, e_exc);
      chk("m_deq_cause", bus.deq_exc_cause, e_cause);
      chk("m_count", bus.count, exp_q.size());
      chk("m_empty", bus.empty, exp_q.size() == 0);
      chk("m_full", bus.full, exp_q.size() == DEPTH);
      chk("m_enq_ready", bus.enq_ready, ready);
    end
    n_deq = bus.deq_ready ? $countones(e_valid) : 0;
    @(posedge clk);
    if (bus.flush) exp_q.delete();
    else begin
      repeat (n_deq) void'(exp_q.pop_front());
      if (ready)
        for (int i = 0; i < ENQ_W; i++)
          if (bus.enq_valid[i])
            exp_q.push_back({bus.enq_bp_xcpt_if[i], bus.enq_bp_debug_if[i], bus.enq_xcpt_ae_if[i],
                             bus.enq_xcpt_pf_if[i], bus.enq_is_sfb[i], bus.enq_instr[32*i +: 32]});
    end
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [ENQ_W-1:0] ev;
    logic [ENQ_W*32-1:0] ei;
    logic [ENQ_W-1:0] sfb, pf, ae, bpd, bpx;
    logic intr, dr;
    logic [DEQ_W-1:0] x_valid;
    logic [DEQ_W*32-1:0] x_instr;
    logic [DEQ_W-1:0] x_sfb, x_exc;
    logic [DEQ_W*XLEN-1:0] x_cause;
    logic [CW-1:0] x_count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [1:0] ev, input logic [63:0] ei, input logic [1:0] sfb,
                              input logic [1:0] pf, input logic [1:0] ae, input logic [1:0] bpd,
                              input logic [1:0] bpx, input logic intr, input logic dr,
                              input logic [1:0] x_valid, input logic [63:0] x_instr,
                              input logic [1:0] x_sfb, input logic [1:0] x_exc,
                              input logic [127:0] x_cause, input logic [3:0] x_count);
    vec_t v;
    v.ev = ev; v.ei = ei; v.sfb = sfb; v.pf = pf; v.ae = ae; v.bpd = bpd; v.bpx = bpx;
    v.intr = intr; v.dr = dr; v.x_valid = x_valid; v.x_instr = x_instr; v.x_sfb = x_sfb;
    v.x_exc = x_exc; v.x_cause = x_cause; v.x_count = x_count;
    vecs.push_back(v);
  endfunction

  function automatic logic [ENQ_W-1:0] rare_bits();
    logic [ENQ_W-1:0] b;
    for (int i = 0; i < ENQ_W; i++) b[i] = ($urandom_range(0, 9) == 0);
    return b;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rstn = 1'b0;
    idle();

    //  ev     instr                          sfb    pf     ae     bpd    bpx    irq  dr | valid  instr                          sfb    exc    cause                      count
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b11, {32'h00100093, 32'h00000013},  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b11, {32'h00100093, 32'h00000013},  2'b00, 2'b00, 128'h0,                    2);
    add(2'b10, {32'hABCD0037, 32'hDEADBEEF},  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b01, {32'h0, 32'hABCD0037},         2'b00, 2'b00, 128'h0,                    1);
    add(2'b11, {32'h00000193, 32'h00000113},  2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 0,   0,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b11, {32'h00000193, 32'h00000113},  2'b00, 2'b10, {64'd3, 64'd0},           2);
    add(2'b11, {32'h00000293, 32'h00000213},  2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0,   0,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b01, {32'h0, 32'h00000213},         2'b00, 2'b01, {64'd0, 64'd12},          2);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b01, {32'h0, 32'h00000293},         2'b00, 2'b00, 128'h0,                    1);
    add(2'b11, {32'h00000393, 32'h00000313},  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b01, {32'hFFFFFFFF, 32'h00000413},  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0,  2'b11, {32'h00000393, 32'h00000313},  2'b10, 2'b00, 128'h0,                    2);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1,   1,  2'b01, {32'h0, 32'h00000313},         2'b00, 2'b01, {64'd0, IRQ_CAUSE},       3);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   0,  2'b11, {32'h00000413, 32'h00000393},  2'b01, 2'b00, 128'h0,                    2);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b11, {32'h00000413, 32'h00000393},  2'b01, 2'b00, 128'h0,                    2);
    add(2'b11, {32'h00000593, 32'h00000513},  2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 0,   0,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b01, {32'h0, 32'h00000513},         2'b00, 2'b01, {64'd0, 64'd12},          2);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b01, {32'h0, 32'h00000593},         2'b00, 2'b01, {64'd0, 64'd14},          1);
    add(2'b11, {32'h00000693, 32'h00000613},  2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 0,   0,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b01, {32'h0, 32'h00000613},         2'b00, 2'b01, {64'd0, 64'd1},           2);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0,   1,  2'b01, {32'h0, 32'h00000693},         2'b00, 2'b00, 128'h0,                    1);
    add(2'b00, 64'h0,                         2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1,   1,  2'b00, 64'h0,                         2'b00, 2'b00, 128'h0,                    0);

    reset_dut();
    foreach (vecs[k]) begin
      drive(1'b0, vecs[k].ev, vecs[k].ei, vecs[k].sfb, vecs[k].pf, vecs[k].ae, vecs[k].bpd,
            vecs[k].bpx, vecs[k].intr, IRQ_CAUSE, vecs[k].dr);
      #1;
      chk($sformatf("v%0d_valid", k), bus.deq_valid, vecs[k].x_valid);
      chk($sformatf("v%0d_instr", k), bus.deq_instr, vecs[k].x_instr);
      chk($sformatf("v%0d_sfb", k), bus.deq_is_sfb, vecs[k].x_sfb);
      chk($sformatf("v%0d_exc", k), bus.deq_exception, vecs[k].x_exc);
      chk($sformatf("v%0d_cause", k), bus.deq_exc_cause, vecs[k].x_cause);
      chk($sformatf("v%0d_count", k), bus.count, vecs[k].x_count);
      chk($sformatf("v%0d_empty", k), bus.empty, vecs[k].x_count == 0);
      chk($sformatf("v%0d_full", k), bus.full, vecs[k].x_count == DEPTH);
      chk($sformatf("v%0d_enq_ready", k), bus.enq_ready, (DEPTH - int'(vecs[k].x_count)) >= ENQ_W);
      run_cycle(0);
    end

    // Fill to 7, overflow attempt ignored, then enq+deq at 6 across the wrap.
    reset_dut();
    enq2(32'h1000_0001, 32'h1000_0002, 1'b0); run_cycle(1);
    enq2(32'h1000_0003, 32'h1000_0004, 1'b0); run_cycle(1);
    enq2(32'h1000_0005, 32'h1000_0006, 1'b0); run_cycle(1);
    drive(1'b0, 2'b01, {32'h0, 32'h1000_0007}, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0); run_cycle(1);
    chk("fill7_count", bus.count, 7);
    enq2(32'hBAD0_0001, 32'hBAD0_0002, 1'b0);
    #1 chk("fill7_enq_ready", bus.enq_ready, 1'b0);
    run_cycle(1);
    chk("fill7_ignored_count", bus.count, 7);
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b1); run_cycle(1);
    drive(1'b0, 2'b01, {32'h0, 32'h1000_0008}, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0); run_cycle(1);
    chk("wrap_pre_count", bus.count, 6);
    enq2(32'h1000_0009, 32'h1000_000A, 1'b1);
    #1 chk("wrap_enq_ready", bus.enq_ready, 1'b1);
    run_cycle(1);
    chk("wrap_post_count", bus.count, 6);
    repeat (4) begin
      drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b1); run_cycle(1);
    end
    chk("wrap_drained", bus.empty, 1'b1);

    // Flush beats same-cycle enqueue and dequeue.
    enq2(32'h2000_0001, 32'h2000_0002, 1'b0); run_cycle(1);
    enq2(32'h2000_0003, 32'h2000_0004, 1'b0); run_cycle(1);
    chk("flush_pre_count", bus.count, 4);
    drive(1'b1, 2'b11, {32'h2000_0006, 32'h2000_0005}, '0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
    run_cycle(1);
    chk("flush_count", bus.count, 0);
    chk("flush_empty", bus.empty, 1'b1);
    idle(); run_cycle(1);

    // Asynchronous reset in the middle of filling.
    enq2(32'h3000_0001, 32'h3000_0002, 1'b0); run_cycle(1);
    enq2(32'h3000_0003, 32'h3000_0004, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_empty", bus.empty, 1'b1);
    chk("arst_deq_valid", bus.deq_valid, 2'b00);
    chk("arst_enq_ready", bus.enq_ready, 1'b1);
    idle();
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;

    // Randomised traffic against the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic dr;
      dr = ((cyc % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), {$urandom, $urandom},
            2'($urandom_range(0, 3)), rare_bits(), rare_bits(), rare_bits(), rare_bits(),
            $urandom_range(0, 9) == 0, {$urandom, $urandom}, dr);
      run_cycle(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
